iob_axi_burst_writer: RTL
=========================

# iob_axi_burst_writer

AXI4 write-only initiator that drains a valid/ready word stream into memory as INCR bursts. It is the initiator end of the AXI write path whose responder is the `axi_ram` DDR model in simulation and the DDR controller in FPGA builds. Typical uses are testbench DDR preload and DMA-style writes from an IOb-SoC peripheral. It keeps one burst outstanding at a time, splits long transfers into bursts, and reports completion and write-response errors.

## Interface

**Parameters**
- AXI_ID_W, 4: ID width.
- AXI_LEN_W, 8: awlen width.
- AXI_ADDR_W, 24: byte address width.
- AXI_DATA_W, 32: data width; power of two, at least 8.
- MAX_BURST, 16: maximum beats per burst, 1..2^AXI_LEN_W.
- CNT_W, 16: width of the transfer word count.

**Ports**
- clk_i, in, 1: system clock.
- arst_i, in, 1: reset, asynchronous and active-high.
- start_i, in, 1: pulse that starts a transfer; ignored while busy_o=1.
- addr_i, in, AXI_ADDR_W: start byte address, sampled on start; low log2(AXI_DATA_W/8) bits are forced to 0.
- len_i, in, CNT_W: number of words, sampled on start.
- data_i, in, AXI_DATA_W: stream data.
- valid_i, in, 1: stream valid.
- ready_o, out, 1: stream ready.
- busy_o, out, 1: transfer in progress.
- done_o, out, 1: one-cycle pulse at transfer end.
- err_o, out, 1: sticky flag, set by any bresp≠OKAY; cleared on an accepted start.
- axi_awid_o, AXI_ID_W; axi_awaddr_o, AXI_ADDR_W; axi_awlen_o, AXI_LEN_W; axi_awsize_o, 3; axi_awburst_o, 2; axi_awlock_o, 2; axi_awcache_o, 4; axi_awprot_o, 3; axi_awqos_o, 4; axi_awvalid_o, 1: all out. axi_awready_i, in, 1.
- axi_wdata_o, AXI_DATA_W; axi_wstrb_o, AXI_DATA_W/8; axi_wlast_o, 1; axi_wvalid_o, 1: all out. axi_wready_i, in, 1.
- axi_bid_i, in, AXI_ID_W; axi_bresp_i, in, 2; axi_bvalid_i, in, 1; axi_bready_o, out, 1.

## Operation

**Constant AXI fields**
- awid=0, awsize=log2(AXI_DATA_W/8), awburst=2'b01 (INCR), awlock=0, awcache=4'b0011, awprot=0, awqos=0.
- wstrb is all ones.

**FSM states:** IDLE, ADDR, DATA, RESP.

- **IDLE:** on start_i:
  - len_i=0: pulse done_o, stay in IDLE, issue no AXI traffic.
  - otherwise: latch addr and remaining count, clear err_o, go to ADDR.
- **ADDR:** compute beats = min(remaining, MAX_BURST) and apply the boundary limit from Configuration.
  - Drive awaddr=addr, awlen=beats-1, awvalid=1.
  - On awready, go to DATA.
- **DATA:** stream passes straight through: wvalid=valid_i, wdata=data_i, ready_o=wready.
  - A beat counts on wvalid&&wready.
  - wlast=1 when beat_cnt=beats-1.
  - Go to RESP on the last beat handshake.
- **RESP:** bready=1. On bvalid:
  - err_o |= (bresp≠2'b00).
  - addr += beats·(AXI_DATA_W/8), modulo 2^AXI_ADDR_W.
  - remaining -= beats.
  - remaining=0: pulse done_o, go to IDLE. Otherwise go to ADDR.
- An error response does not abort the transfer.
- bid is ignored.
- ready_o=0 outside DATA.
- busy_o=1 in every state except IDLE.

## Timing

- **Reset values:** all outputs 0, except the constant AXI fields, which hold their fixed values. State resets to IDLE.
- **Reset mid-transfer:** abandons the transfer immediately. No done_o is produced. The responder is expected to be reset by the same arst_i.
- **Start latency:** start_i accepted in cycle N gives awvalid=1 in cycle N+1.
- **Address channel:** awvalid, awaddr and awlen are registered and stable until the awready handshake.
- **Data channel:**
  - wvalid and wdata are combinational from valid_i and data_i, so there is zero added latency in DATA.
  - Full throughput is 1 beat/cycle.
  - wlast is registered from beat_cnt.
- **No overlap:** the first beat of a burst is not offered before the AW handshake.
- **Burst-to-burst gap:** bvalid in cycle M gives awvalid of the next burst in M+1, and done_o in M+1 for the final burst.
- **Counters:**
  - beat_cnt is AXI_LEN_W+1 bits.
  - remaining is CNT_W bits and never underflows.

## Configuration

- **IOB_AXI_BURST_WRITER_BOUNDARY_4K_EN**
  - Defined: beats is additionally limited to the words left before the next 4 KB address boundary, (4096 − addr[11:0])/(AXI_DATA_W/8). No burst crosses a 4 KB boundary, as AXI4 requires.
  - Undefined: beats = min(remaining, MAX_BURST). The caller guarantees boundary legality. The boundary logic is removed.

## Test plan

1. **Single burst:** addr_i=0x100, len_i=4, valid_i=1, all readys=1 → one AW with awaddr=0x100, awlen=3; 4 beats with wlast on the 4th; done_o 1 cycle after bvalid; err_o=0.
2. **Burst split:** MAX_BURST=16, addr_i=0, len_i=40 → three bursts: awaddr 0x0/0x40/0x80 with awlen 15/15/7; exactly 40 beats in stream order.
3. **4 KB boundary:** addr_i=0xFF8, len_i=4.
   - With the _EN macro: awlen=1 @0xFF8, then awlen=1 @0x1000.
   - Without it: a single burst, awlen=3 @0xFF8.
4. **Backpressure:** awready held low for 5 cycles; wready and valid_i toggling at random, len_i=20 → awaddr/awlen stable while waiting; data matches the input sequence; no beat is lost or duplicated.
5. **Error and edge starts:**
   - bresp=2'b10 on the first of 2 bursts → err_o=1, second burst still issued, done_o asserted.
   - A following start clears err_o.
   - len_i=0 → done_o the next cycle with no awvalid.
   - start_i while busy → ignored.
6. **Reset mid-transfer:** arst_i asserted during DATA → same cycle: awvalid/wvalid/bready/busy_o/ready_o=0, state IDLE. A new start after release runs normally.

Source files
------------

// File: rtl/iob_axi_burst_writer.sv
// AXI4 write-only initiator: drains a valid/ready word stream into memory as INCR bursts.
// Optional macro IOB_AXI_BURST_WRITER_BOUNDARY_4K_EN keeps every burst inside one 4 KB page.
module iob_axi_burst_writer #(
  parameter int unsigned AXI_ID_W   = 4,
  parameter int unsigned AXI_LEN_W  = 8,
  parameter int unsigned AXI_ADDR_W = 24,
  parameter int unsigned AXI_DATA_W = 32,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                    clk_i,
  input  logic                    arst_i,
  input  logic                    start_i,
  input  logic [AXI_ADDR_W-1:0]   addr_i,
  input  logic [CNT_W-1:0]        len_i,
  input  logic [AXI_DATA_W-1:0]   data_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [AXI_ID_W-1:0]     axi_awid_o,
  output logic [AXI_ADDR_W-1:0]   axi_awaddr_o,
  output logic [AXI_LEN_W-1:0]    axi_awlen_o,
  output logic [2:0]              axi_awsize_o,
  output logic [1:0]              axi_awburst_o,
  output logic [1:0]              axi_awlock_o,
  output logic [3:0]              axi_awcache_o,
  output logic [2:0]              axi_awprot_o,
  output logic [3:0]              axi_awqos_o,
  output logic                    axi_awvalid_o,
  input  logic                    axi_awready_i,
  output logic [AXI_DATA_W-1:0]   axi_wdata_o,
  output logic [AXI_DATA_W/8-1:0] axi_wstrb_o,
  output logic                    axi_wlast_o,
  output logic                    axi_wvalid_o,
  input  logic                    axi_wready_i,
  input  logic [AXI_ID_W-1:0]     axi_bid_i,
  input  logic [1:0]              axi_bresp_i,
  input  logic                    axi_bvalid_i,
  output logic                    axi_bready_o
);

  localparam int unsigned STRB_W = AXI_DATA_W / 8;
  localparam int unsigned OFF    = $clog2(STRB_W);
  localparam int unsigned BW     = AXI_LEN_W + 1;
  localparam int unsigned MW     = CNT_W + BW + 13;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic [AXI_ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]        rem_q, rem_d;
  logic [BW-1:0]           beats_q, beats_d;
  logic [BW-1:0]           beat_cnt_q, beat_cnt_d;
  logic                    wlast_q, wlast_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    aw_hs, w_hs, b_hs;
  logic [MW-1:0]           lim;
  logic                    unused_sig;

  assign aw_hs = (state_q == S_ADDR) && axi_awready_i;
  assign w_hs  = (state_q == S_DATA) && valid_i && axi_wready_i;
  assign b_hs  = (state_q == S_RESP) && axi_bvalid_i;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_i && (len_i != '0)) state_d = S_ADDR;
      S_ADDR: if (aw_hs) state_d = S_DATA;
      S_DATA: if (w_hs && wlast_q) state_d = S_RESP;
      S_RESP: if (b_hs) state_d = ((rem_q - CNT_W'(beats_q)) == '0) ? S_IDLE : S_ADDR;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    axi_awvalid_o = (state_q == S_ADDR);
    axi_awaddr_o  = addr_q;
    axi_awlen_o   = (state_q == S_ADDR) ? AXI_LEN_W'(beats_q - BW'(1)) : '0;
    axi_wvalid_o  = (state_q == S_DATA) && valid_i;
    axi_wdata_o   = (state_q == S_DATA) ? data_i : '0;
    axi_wlast_o   = wlast_q;
    ready_o       = (state_q == S_DATA) && axi_wready_i;
    axi_bready_o  = (state_q == S_RESP);
    busy_o        = (state_q != S_IDLE);
    done_o        = done_q;
    err_o         = err_q;
  end

  assign axi_awid_o    = '0;
  assign axi_awsize_o  = 3'(OFF);
  assign axi_awburst_o = 2'b01;
  assign axi_awlock_o  = 2'b00;
  assign axi_awcache_o = 4'b0011;
  assign axi_awprot_o  = 3'b000;
  assign axi_awqos_o   = 4'b0000;
  assign axi_wstrb_o   = '1;

  // Transfer bookkeeping: address/remaining advance only once the burst is acknowledged.
  always_comb begin
    addr_d     = addr_q;
    rem_d      = rem_q;
    beat_cnt_d = beat_cnt_q;
    wlast_d    = wlast_q;
    done_d     = 1'b0;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (len_i == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d = addr_i & ~AXI_ADDR_W'(STRB_W - 1);
            rem_d  = len_i;
            err_d  = 1'b0;
          end
        end
      end
      S_ADDR: begin
        if (aw_hs) begin
          beat_cnt_d = '0;
          wlast_d    = (beats_q == BW'(1));
        end
      end
      S_DATA: begin
        if (w_hs) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
          wlast_d    = ((beat_cnt_q + BW'(2)) == beats_q);
        end
      end
      S_RESP: begin
        if (b_hs) begin
          err_d  = err_q | (axi_bresp_i != 2'b00);
          addr_d = addr_q + (AXI_ADDR_W'(beats_q) << OFF);
          rem_d  = rem_q - CNT_W'(beats_q);
          done_d = (rem_d == '0);
        end
      end
      default: ;
    endcase
  end

`ifdef IOB_AXI_BURST_WRITER_BOUNDARY_4K_EN
  logic [12:0] w4k;
  assign w4k = (13'h1000 - {1'b0, addr_d[11:0]}) >> OFF;
`endif

  // Burst length is fixed when entering ADDR, from the address/count it will use.
  always_comb begin
    lim = MW'(rem_d);
    if (lim > MW'(MAX_BURST)) lim = MW'(MAX_BURST);
`ifdef IOB_AXI_BURST_WRITER_BOUNDARY_4K_EN
    if (lim > MW'(w4k)) lim = MW'(w4k);
`endif
    beats_d = ((state_d == S_ADDR) && (state_q != S_ADDR)) ? BW'(lim) : beats_q;
  end

  assign unused_sig = ^{axi_bid_i, lim};

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      addr_q     <= '0;
      rem_q      <= '0;
      beats_q    <= '0;
      beat_cnt_q <= '0;
      wlast_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      beats_q    <= beats_d;
      beat_cnt_q <= beat_cnt_d;
      wlast_q    <= wlast_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule
